// File: rtl/simp_fun_pkg.sv
// Shared types for the pipelined-function driver: run-sequencer states and the
// result-capture tag that travels alongside each issued vector.
package simp_fun_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_HOLD,
        ST_DRIVE,
        ST_FLUSH,
        ST_DONE
    } drv_state_t;

    // Wide enough for any practical table depth; the driver zero-extends its index.
    localparam int TAG_IDX_W = 16;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/simp_fun_tag_pipe.sv
// LATENCY-deep tag delay line; tag_o is tag_i delayed by LATENCY clock edges.
// No backpressure: shifts every cycle, synchronous reset clears all stages.
module simp_fun_tag_pipe
    import simp_fun_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t pipe_q [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            pipe_q[0] <= tag_i;
            for (int k = 1; k < LATENCY; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    assign tag_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/simp_fun_driver.sv
// Self-test initiator: holds the function block in reset, streams the loaded vector
// table one per cycle, flushes LATENCY cycles and captures results; no backpressure.
module simp_fun_driver
    import simp_fun_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 8,
    parameter int LATENCY    = 2,
    parameter int RST_CYCLES = 3,
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_clr,
    input  logic             ld_valid,
    input  logic [WIDTH-1:0] ld_a,
    input  logic [WIDTH-1:0] ld_b,
    output logic             ld_ready,
    input  logic             start,
    output logic             dut_rst,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic [WIDTH-1:0] c_in,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } vec_t;

    localparam int CYC_MAX = (RST_CYCLES > LATENCY) ? RST_CYCLES : LATENCY;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    drv_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    vec_t             drive_q, drive_d;
    logic             dut_rst_q, dut_rst_d;
    logic [WIDTH-1:0] rd_data_q;
    logic             ld_we;
    logic             last_vec;

    vec_t             table_q  [DEPTH];
    logic [WIDTH-1:0] result_q [DEPTH];

    tag_t tag_in, tag_out;

    assign ld_ready = (state_q == ST_IDLE) && (count_q < CNT_W'(DEPTH));
    assign last_vec = ((CNT_W'(idx_q) + CNT_W'(1)) == count_q);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        cyc_d   = cyc_q;
        drive_d = '0;
        ld_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Clear beats a same-cycle load; a load alongside start joins the run.
                if (ld_clr) begin
                    count_d = '0;
                end else if (ld_valid && ld_ready) begin
                    ld_we   = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end
                if (start) begin
                    state_d = ST_RST_HOLD;
                    cyc_d   = '0;
                end
            end
            ST_RST_HOLD: begin
                if (cyc_q == CYC_W'(RST_CYCLES - 1)) begin
                    cyc_d = '0;
                    idx_d = '0;
                    if (count_q == '0) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_DRIVE;
                        drive_d = table_q[0];
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            ST_DRIVE: begin
                if (last_vec) begin
                    state_d = ST_FLUSH;
                    cyc_d   = '0;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    drive_d = table_q[idx_d];
                end
            end
            ST_FLUSH: begin
                if (cyc_q == CYC_W'(LATENCY - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dut_rst_d = (state_d == ST_RST_HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            idx_q     <= '0;
            cyc_q     <= '0;
            drive_q   <= '0;
            dut_rst_q <= 1'b1;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            cyc_q     <= cyc_d;
            drive_q   <= drive_d;
            dut_rst_q <= dut_rst_d;
            rd_data_q <= result_q[rd_idx];
        end
    end

    assign tag_in = '{valid: (state_q == ST_DRIVE), idx: TAG_IDX_W'(idx_q)};

    simp_fun_tag_pipe #(
        .LATENCY(LATENCY)
    ) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    // Storage arrays carry no reset; only entries named by a live tag are written.
    always_ff @(posedge clk) begin
        if (!rst && ld_we) begin
            table_q[count_q[IDX_W-1:0]] <= '{a: ld_a, b: ld_b};
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (!rst && tag_out.valid && (tag_out.idx == TAG_IDX_W'(k))) begin
                result_q[k] <= c_in;
            end
        end
    end

    assign dut_rst = dut_rst_q;
    assign a_out   = drive_q.a;
    assign b_out   = drive_q.b;
    assign rd_data = rd_data_q;
    assign count   = count_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_simp_fun_driver.sv
// Bench for simp_fun_driver: driven block modelled as c = a + b over two stages,
// run-level timeline model checked every cycle plus literal scenario checks.
module tb_simp_fun_driver;

    localparam int WIDTH      = 16;
    localparam int DEPTH      = 8;
    localparam int LATENCY    = 2;
    localparam int RST_CYCLES = 3;
    localparam int IDX_W      = 3;
    localparam int CNT_W      = 4;

    logic             clk;
    logic             rst;
    logic             ld_clr;
    logic             ld_valid;
    logic [WIDTH-1:0] ld_a;
    logic [WIDTH-1:0] ld_b;
    logic             ld_ready;
    logic             start;
    logic             dut_rst;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic [WIDTH-1:0] c_in;
    logic [IDX_W-1:0] rd_idx;
    logic [WIDTH-1:0] rd_data;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    simp_fun_driver #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LATENCY), .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .ld_clr(ld_clr), .ld_valid(ld_valid),
        .ld_a(ld_a), .ld_b(ld_b), .ld_ready(ld_ready), .start(start),
        .dut_rst(dut_rst), .a_out(a_out), .b_out(b_out), .c_in(c_in),
        .rd_idx(rd_idx), .rd_data(rd_data), .count(count), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driven block: two register stages computing a + b.
    logic [WIDTH-1:0] blk_s1, blk_s2;
    always @(posedge clk) begin
        if (dut_rst) begin
            blk_s1 <= '0;
            blk_s2 <= '0;
        end else begin
            blk_s1 <= a_out + b_out;
            blk_s2 <= blk_s1;
        end
    end
    assign c_in = blk_s2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Run model: a run is a timeline of phases counted from the start edge.
    logic [WIDTH-1:0] m_ta [DEPTH];
    logic [WIDTH-1:0] m_tb [DEPTH];
    logic [WIDTH-1:0] m_res [DEPTH];
    bit               m_known [DEPTH];
    int               m_cnt   = 0;
    int               m_phase = -1;
    int               m_n     = 0;
    bit               m_live  = 0;
    bit               m_rst_seen = 0;
    bit               m_rd_vld = 0;
    logic [WIDTH-1:0] m_rd = '0;

    always @(posedge clk) begin
        int k;
        if (rst) begin
            m_live     = 1;
            m_rst_seen = 1;
            m_phase    = -1;
            m_cnt      = 0;
            m_rd       = '0;
            m_rd_vld   = 1;
            for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
        end else if (m_live) begin
            m_rst_seen = 0;
            m_rd_vld   = m_known[rd_idx];
            m_rd       = m_res[rd_idx];
            if (m_phase < 0) begin
                if (ld_clr) begin
                    m_cnt = 0;
                end else if (ld_valid && m_cnt < DEPTH) begin
                    m_ta[m_cnt] = ld_a;
                    m_tb[m_cnt] = ld_b;
                    m_cnt++;
                end
                if (start) begin
                    m_phase = 0;
                    m_n     = m_cnt;
                end
            end else begin
                m_phase++;
                // Vector k shows in phase R+k, is sampled one edge later, lands LATENCY edges after.
                k = m_phase - RST_CYCLES - 1 - LATENCY;
                if (k >= 0 && k < m_n) begin
                    m_res[k]   = m_ta[k] + m_tb[k];
                    m_known[k] = 1;
                end
                if (m_phase > RST_CYCLES + m_n + LATENCY) m_phase = -1;
            end
        end
    end

    always @(negedge clk) begin
        logic [WIDTH-1:0] ea, eb;
        bit drv;
        if (m_live) begin
            drv = (m_phase >= RST_CYCLES) && (m_phase < RST_CYCLES + m_n);
            ea  = drv ? m_ta[m_phase - RST_CYCLES] : '0;
            eb  = drv ? m_tb[m_phase - RST_CYCLES] : '0;
            check("busy",     32'(busy),     32'(m_phase >= 0));
            check("done",     32'(done),     32'(m_phase == RST_CYCLES + m_n + LATENCY));
            check("dut_rst",  32'(dut_rst),  32'(m_rst_seen || (m_phase >= 0 && m_phase < RST_CYCLES)));
            check("a_out",    32'(a_out),    32'(ea));
            check("b_out",    32'(b_out),    32'(eb));
            check("count",    32'(count),    32'(m_cnt));
            check("ld_ready", 32'(ld_ready), 32'(m_phase < 0 && m_cnt < DEPTH));
            if (m_rd_vld) check("rd_data", 32'(rd_data), 32'(m_rd));
        end
    end

    logic [WIDTH-1:0] rec_a [128];
    logic             rec_r [128];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input int b);
        ld_valid = 1'b1;
        ld_a     = WIDTH'(a);
        ld_b     = WIDTH'(b);
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic clear();
        ld_clr = 1'b1;
        tick();
        ld_clr = 1'b0;
    endtask

    // Start a run, optionally firing ignored requests at cycle inj_c; returns start-to-done cycles.
    task automatic run(input int inj_c, output int cyc);
        int c;
        start = 1'b1;
        tick();
        start    = 1'b0;
        ld_valid = 1'b0;
        c = 1;
        rec_a[c] = a_out;
        rec_r[c] = dut_rst;
        while (done !== 1'b1 && c < 100) begin
            if (c == inj_c) begin
                start = 1'b1; ld_valid = 1'b1; ld_clr = 1'b1;
                ld_a = 16'd99; ld_b = 16'd99;
            end
            rd_idx = IDX_W'($urandom_range(0, DEPTH - 1));
            tick();
            start = 1'b0; ld_valid = 1'b0; ld_clr = 1'b0;
            c++;
            rec_a[c] = a_out;
            rec_r[c] = dut_rst;
        end
        check("run_reaches_done", 32'(done), 32'(1));
        cyc = c;
        tick();
    endtask

    task automatic rd_check(input string nm, input int idx, input int exp);
        rd_idx = IDX_W'(idx);
        tick();
        check(nm, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int nrst;
        logic [WIDTH-1:0] exp_a [5];
        int exp_c [5];
        exp_a = '{16'd5, 16'd10, 16'd100, 16'd0, 16'd255};
        exp_c = '{12, 30, 150, 0, 510};

        rst = 1'b1; ld_clr = 1'b0; ld_valid = 1'b0; start = 1'b0;
        ld_a = '0; ld_b = '0; rd_idx = '0;
        tick();
        check("rst_busy",     32'(busy),     32'(0));
        check("rst_done",     32'(done),     32'(0));
        check("rst_dut_rst",  32'(dut_rst),  32'(1));
        check("rst_count",    32'(count),    32'(0));
        check("rst_ld_ready", 32'(ld_ready), 32'(1));
        check("rst_rd_data",  32'(rd_data),  32'(0));
        check("rst_a_out",    32'(a_out),    32'(0));
        tick();
        rst = 1'b0;
        tick();

        // Full run
        load(5, 7); load(10, 20); load(100, 50); load(0, 0); load(255, 255);
        check("full_count", 32'(count), 32'(5));
        run(-1, cyc);
        check("full_cycles", 32'(cyc), 32'(11));
        nrst = 0;
        for (int c = 1; c <= cyc; c++) nrst += int'(rec_r[c]);
        check("full_dut_rst_len", 32'(nrst), 32'(3));
        for (int i = 0; i < 5; i++) check("full_a_seq", 32'(rec_a[4 + i]), 32'(exp_a[i]));
        for (int i = 0; i < 5; i++) rd_check("full_result", i, exp_c[i]);

        // Requests during DRIVE are ignored
        run(5, cyc);
        check("ign_cycles", 32'(cyc), 32'(11));
        check("ign_count",  32'(count), 32'(5));
        for (int i = 0; i < 5; i++) rd_check("ign_result", i, exp_c[i]);

        // Empty run keeps stale results
        clear();
        check("empty_count", 32'(count), 32'(0));
        run(-1, cyc);
        check("empty_cycles", 32'(cyc), 32'(6));
        for (int i = 0; i < 5; i++) rd_check("empty_stale", i, exp_c[i]);

        // Full table
        for (int i = 0; i < DEPTH; i++) load(i, 1);
        check("ft_ld_ready", 32'(ld_ready), 32'(0));
        load(100, 100);
        check("ft_count_9th", 32'(count), 32'(8));
        run(-1, cyc);
        check("ft_cycles", 32'(cyc), 32'(14));
        for (int i = 0; i < DEPTH; i++) rd_check("ft_result", i, i + 1);

        // Clear beats load; load alongside start joins the run
        ld_clr = 1'b1; ld_valid = 1'b1; ld_a = 16'd7; ld_b = 16'd7;
        tick();
        ld_clr = 1'b0; ld_valid = 1'b0;
        check("sim_clr_wins", 32'(count), 32'(0));
        load(1, 2); load(3, 4);
        ld_valid = 1'b1; ld_a = 16'd9; ld_b = 16'd9;
        run(-1, cyc);
        check("sim_count",  32'(count), 32'(3));
        check("sim_cycles", 32'(cyc),   32'(9));
        rd_check("sim_last", 2, 18);

        // Reset in DRIVE cycle 2
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < 6) begin tick(); cyc++; end
        check("mid_in_drive", 32'(busy), 32'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_busy",     32'(busy),     32'(0));
        check("mid_count",    32'(count),    32'(0));
        check("mid_dut_rst",  32'(dut_rst),  32'(1));
        check("mid_ld_ready", 32'(ld_ready), 32'(1));
        check("mid_done",     32'(done),     32'(0));
        tick();
        load(3, 4);
        run(-1, cyc);
        rd_check("mid_rerun", 0, 7);

        // Randomized loads and runs, checked by the per-cycle model
        for (int it = 0; it < 8; it++) begin
            clear();
            for (int j = 0; j < 14; j++) begin
                ld_valid = 1'($urandom_range(0, 1));
                ld_clr   = ($urandom_range(0, 9) == 0);
                ld_a     = WIDTH'($urandom);
                ld_b     = WIDTH'($urandom);
                rd_idx   = IDX_W'($urandom_range(0, DEPTH - 1));
                tick();
            end
            ld_valid = 1'b0; ld_clr = 1'b0;
            run(-1, cyc);
            for (int i = 0; i < DEPTH; i++) begin
                rd_idx = IDX_W'(i);
                tick();
            end
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
